// File: rtl/dm_access_ctrl_if.sv
// Requester-side bus of dm_access_ctrl: two request ports sharing one response path.
interface dm_access_ctrl_if;
    logic        req0, we0, sext0, ack0;
    logic [1:0]  size0;
    logic [31:0] addr0, wdata0;
    logic        req1, we1, sext1, ack1;
    logic [1:0]  size1;
    logic [31:0] addr1, wdata1;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req0, we0, size0, sext0, addr0, wdata0,
        output req1, we1, size1, sext1, addr1, wdata1,
        input  ack0, ack1, rdata, err
    );

    modport slave (
        input  req0, we0, size0, sext0, addr0, wdata0,
        input  req1, we1, size1, sext1, addr1, wdata1,
        output ack0, ack1, rdata, err
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Two-port arbiter/sequencer for a word-wide data memory: sub-word loads,
// read-modify-write sub-word stores, alignment checking.
module dm_access_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    dm_access_ctrl_if.slave bus,
    output logic            busy,
    output logic [31:0]     mem_addr,
    output logic            mem_we,
    output logic [31:0]     mem_din,
    input  logic [31:0]     mem_dout
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;

    // Only what later states need: byte lane and the low half of store data.
    typedef struct packed {
        logic        port;
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [1:0]  lane;
        logic [15:0] wdata;
    } op_t;

    state_t      state, state_nx;
    op_t         op;
    logic        last_grant;
    logic        ack0_q, ack1_q, err_q;
    logic [31:0] rdata_q;

    logic        any_req, gnt_port, gnt_we, gnt_sext, gnt_misal;
    logic [1:0]  gnt_size;
    logic [31:0] gnt_addr, gnt_wdata, gnt_addr_al;
    logic [31:0] lane_data, load_data, merge_data;
    logic        unused_addr;

    always_comb begin
        any_req   = bus.req0 | bus.req1;
        gnt_port  = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;
        gnt_we    = gnt_port ? bus.we1    : bus.we0;
        gnt_size  = gnt_port ? bus.size1  : bus.size0;
        gnt_sext  = gnt_port ? bus.sext1  : bus.sext0;
        gnt_addr  = gnt_port ? bus.addr1  : bus.addr0;
        gnt_wdata = gnt_port ? bus.wdata1 : bus.wdata0;

        // Low bits are cleared even when checking; a misaligned op never uses them.
        gnt_misal   = 1'b0;
        gnt_addr_al = gnt_addr;
        if (gnt_size[1]) begin
            gnt_misal         = |gnt_addr[1:0];
            gnt_addr_al[1:0]  = 2'b00;
        end else if (gnt_size[0]) begin
            gnt_misal         = gnt_addr[0];
            gnt_addr_al[0]    = 1'b0;
        end
        gnt_misal = gnt_misal & CHECK_ALIGN;
    end

    // Bits above ADDR_WIDTH are dropped on purpose (address aliasing).
    assign unused_addr = ^gnt_addr_al;

    always_comb begin
        lane_data = mem_dout >> {op.lane, 3'b000};
        case (op.size)
            2'b00:   load_data = {{24{op.sext & lane_data[7]}},  lane_data[7:0]};
            2'b01:   load_data = {{16{op.sext & lane_data[15]}}, lane_data[15:0]};
            default: load_data = mem_dout;
        endcase
        merge_data = mem_dout;
        if (op.size[0]) merge_data[{op.lane[1], 4'b0000} +: 16] = op.wdata;
        else            merge_data[{op.lane, 3'b000} +: 8]       = op.wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = gnt_misal ? DONE : ACCESS;
            ACCESS:  state_nx = (op.we && !op.size[1]) ? MERGE : DONE;
            MERGE:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        mem_we = !reset && ((state == ACCESS && op.we && op.size[1]) || state == MERGE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            op         <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    last_grant <= gnt_port;
                    op <= '{port: gnt_port, we: gnt_we, size: gnt_size, sext: gnt_sext,
                            lane: gnt_addr_al[1:0], wdata: gnt_wdata[15:0]};
                    if (gnt_misal) begin
                        {ack1_q, ack0_q} <= gnt_port ? 2'b10 : 2'b01;
                        err_q            <= 1'b1;
                        rdata_q          <= '0;
                    end else begin
                        mem_addr <= 32'(gnt_addr_al[ADDR_WIDTH-1:2]) << 2;
                        if (gnt_we && gnt_size[1]) mem_din <= gnt_wdata;
                    end
                end
                ACCESS: begin
                    if (op.we && !op.size[1]) begin
                        mem_din <= merge_data;
                    end else begin
                        {ack1_q, ack0_q} <= op.port ? 2'b10 : 2'b01;
                        err_q            <= 1'b0;
                        rdata_q          <= op.we ? 32'd0 : load_data;
                    end
                end
                MERGE: begin
                    {ack1_q, ack0_q} <= op.port ? 2'b10 : 2'b01;
                    err_q            <= 1'b0;
                    rdata_q          <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ack0  = ack0_q;
    assign bus.ack1  = ack1_q;
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: directed vector table, reset/arbitration sequences,
// and random traffic checked against a byte-level memory model.
module tb_dm_access_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_clr;
    logic        busy, mem_we;
    logic [31:0] mem_addr, mem_din, mem_dout;

    always #5 clk = ~clk;

    dm_access_ctrl_if bus();

    dm_access_ctrl #(.ADDR_WIDTH(10), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    logic [31:0] mem [0:255];
    assign mem_dout = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
        else if (mem_we) mem[mem_addr[9:2]] <= mem_din;
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] refm [0:1023];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit ref_misal(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    endfunction

    function automatic int ref_nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit sx, input logic [31:0] a);
        logic [31:0] v;
        int n;
        v = 0;
        n = ref_nbytes(sz);
        for (int i = 0; i < n; i++) v |= 32'(refm[(a + i) & 32'h3FF]) << (8 * i);
        if (sx && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 1);
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < ref_nbytes(sz); i++) refm[(a + i) & 32'h3FF] = 8'(wd >> (8 * i));
    endtask

    task automatic drive(input bit p, input bit rq, input bit we, input logic [1:0] sz,
                         input bit sx, input logic [31:0] a, input logic [31:0] wd);
        if (p) begin
            bus.req1 = rq; bus.we1 = we; bus.size1 = sz; bus.sext1 = sx; bus.addr1 = a; bus.wdata1 = wd;
        end else begin
            bus.req0 = rq; bus.we0 = we; bus.size0 = sz; bus.sext0 = sx; bus.addr0 = a; bus.wdata0 = wd;
        end
    endtask

    // Issue one request, wait for its ack; lat counts negedge samples after issue.
    task automatic do_txn(input bit p, input bit we, input logic [1:0] sz, input bit sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit er, output bit ap,
                          output int lat, output int wecnt, output int wefirst);
        bit done;
        @(negedge clk);
        drive(p, 1'b1, we, sz, sx, a, wd);
        rd = 0; er = 0; ap = 0; lat = 0; wecnt = 0; wefirst = 0; done = 0;
        for (int c = 1; c <= 10 && !done; c++) begin
            @(negedge clk);
            lat = c;
            if (mem_we) begin
                wecnt++;
                if (wefirst == 0) wefirst = c;
            end
            if (bus.ack0 || bus.ack1) begin
                ap = bus.ack1; rd = bus.rdata; er = bus.err; done = 1;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL ack timeout: port %0d addr %h got no ack want ack", p, a);
        end
        drive(p, 1'b0, we, sz, sx, a, wd);
    endtask

    task automatic run_txn(input string tag, input bit p, input bit we, input logic [1:0] sz,
                           input bit sx, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
        logic [31:0] rd;
        bit er, ap;
        int lat, wecnt, wefirst;
        do_txn(p, we, sz, sx, a, wd, rd, er, ap, lat, wecnt, wefirst);
        check($sformatf("%s rdata", tag), rd, exp_rd);
        check($sformatf("%s err", tag), 32'(er), 32'(exp_err));
        check($sformatf("%s ack port", tag), 32'(ap), 32'(p));
        check($sformatf("%s latency", tag), lat, exp_lat);
        check($sformatf("%s mem_we cycles", tag), wecnt, (we && !exp_err) ? 1 : 0);
        if (we && !exp_err) begin
            check($sformatf("%s write cycle", tag), wefirst, sz[1] ? 1 : 2);
            ref_store(sz, a, wd);
        end
    endtask

    typedef struct {
        bit          p;
        bit          we;
        logic [1:0]  sz;
        bit          sx;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input bit p, input bit we, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
        vec_t v;
        v.p = p; v.we = we; v.sz = sz; v.sx = sx; v.a = a; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat, n, cyc;

        //   p  we sz     sx addr      wdata         rdata         err lat
        addv(0, 1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 32'h00000000, 0, 2);
        addv(0, 0, 2'b10, 0, 32'h010, 32'h0,        32'hDEADBEEF, 0, 2);
        addv(1, 1, 2'b10, 0, 32'h020, 32'h11223344, 32'h00000000, 0, 2);
        addv(1, 1, 2'b00, 0, 32'h022, 32'h000000AA, 32'h00000000, 0, 3);
        addv(0, 0, 2'b10, 0, 32'h020, 32'h0,        32'h11AA3344, 0, 2);
        addv(0, 0, 2'b00, 1, 32'h022, 32'h0,        32'hFFFFFFAA, 0, 2);
        addv(0, 0, 2'b00, 0, 32'h022, 32'h0,        32'h000000AA, 0, 2);
        addv(1, 1, 2'b10, 0, 32'h024, 32'h01020304, 32'h00000000, 0, 2);
        addv(0, 1, 2'b01, 0, 32'h026, 32'h0000BEEF, 32'h00000000, 0, 3);
        addv(0, 0, 2'b01, 1, 32'h026, 32'h0,        32'hFFFFBEEF, 0, 2);
        addv(1, 0, 2'b01, 0, 32'h026, 32'h0,        32'h0000BEEF, 0, 2);
        addv(0, 0, 2'b00, 0, 32'h024, 32'h0,        32'h00000004, 0, 2);
        addv(0, 0, 2'b00, 0, 32'h025, 32'h0,        32'h00000003, 0, 2);
        addv(0, 0, 2'b10, 0, 32'h013, 32'h0,        32'h00000000, 1, 1);
        addv(1, 0, 2'b01, 0, 32'h011, 32'h0,        32'h00000000, 1, 1);
        addv(1, 1, 2'b10, 0, 32'h012, 32'h12345678, 32'h00000000, 1, 1);
        addv(0, 0, 2'b10, 0, 32'h410, 32'h0,        32'hDEADBEEF, 0, 2);
        addv(1, 0, 2'b11, 0, 32'h010, 32'h0,        32'hDEADBEEF, 0, 2);

        for (int i = 0; i < 1024; i++) refm[i] = 8'h00;
        drive(0, 0, 0, 2'b00, 0, 0, 0);
        drive(1, 0, 0, 2'b00, 0, 0, 0);
        reset = 1'b1; mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ack0", 32'(bus.ack0), 0);
        check("reset ack1", 32'(bus.ack1), 0);
        check("reset rdata", bus.rdata, 0);
        check("reset err", 32'(bus.err), 0);
        check("reset busy", 32'(busy), 0);
        check("reset mem_we", 32'(mem_we), 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_din", mem_din, 0);
        reset = 1'b0; mem_clr = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            run_txn($sformatf("vec%0d", i), vecs[i].p, vecs[i].we, vecs[i].sz, vecs[i].sx,
                    vecs[i].a, vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat);

        // Reset while a byte store sits in MERGE: write and ack must both vanish.
        run_txn("rst pre", 0, 1, 2'b10, 0, 32'h030, 32'h55667788, 32'h0, 0, 2);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 2'b00, 0, 32'h031, 32'h99);
        @(negedge clk);
        check("rst seq access we", 32'(mem_we), 0);
        @(negedge clk);
        check("rst seq merge we", 32'(mem_we), 1);
        reset = 1'b1;
        #1;
        check("rst seq we forced low", 32'(mem_we), 0);
        @(negedge clk);
        check("rst seq ack1", 32'(bus.ack1), 0);
        check("rst seq busy", 32'(busy), 0);
        reset = 1'b0;
        drive(1, 1'b0, 0, 2'b00, 0, 0, 0);

        // Both ports held: expect strict alternation starting at port 0.
        drive(0, 1'b1, 1'b0, 2'b10, 0, 32'h010, 0);
        drive(1, 1'b1, 1'b0, 2'b10, 0, 32'h030, 0);
        n = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.ack0 || bus.ack1) begin
                check($sformatf("rr grant %0d", n), 32'({bus.ack1, bus.ack0}), (n % 2) ? 32'd2 : 32'd1);
                check($sformatf("rr rdata %0d", n), bus.rdata,
                      ref_load(2'b10, 0, (n % 2) ? 32'h030 : 32'h010));
                n++;
            end
        end
        if (n < 4) begin
            total++; bad++;
            $display("FAIL rr timeout: got %0d acks want 4", n);
        end
        drive(0, 1'b0, 0, 2'b00, 0, 0, 0);
        drive(1, 1'b0, 0, 2'b00, 0, 0, 0);
        run_txn("rst post word", 0, 0, 2'b10, 0, 32'h030, 0, 32'h55667788, 0, 2);

        for (int i = 0; i < 60; i++) begin
            bit          p, we, sx;
            logic [1:0]  sz;
            logic [31:0] a, wd;
            p  = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 127)) | (32'($urandom_range(0, 3)) << 10)
               | (32'($urandom_range(0, 1)) << 31);
            wd = $urandom;
            exp_err = ref_misal(sz, a);
            exp_rd  = (!we && !exp_err) ? ref_load(sz, sx, a) : 32'd0;
            exp_lat = exp_err ? 1 : (!we || sz[1]) ? 2 : 3;
            run_txn($sformatf("rand%0d", i), p, we, sz, sx, a, wd, exp_rd, exp_err, exp_lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
Sequencer and arbiter in front of the single-port, byte-addressed, little-endian data memory (1 KiB, combinational read, word write on posedge when MemWrite). Shares the memory between two requesters: port 0 is the CPU load/store unit, port 1 is the debug/loader. Adds byte/halfword loads and stores; sub-word stores use read-modify-write, because the memory writes whole words only. Checks alignment and formats load data.

Parameters:
ADDR_WIDTH, 10, byte-address bits forwarded to memory; mem_addr upper bits driven 0
CHECK_ALIGN, 1, 1 = misaligned access rejected with err; 0 = addr[1:0] forced to 0 for word and addr[0] forced to 0 for half

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
req0  in  1  port 0 request; held with fields stable until ack0
we0  in  1  port 0: 1 = store, 0 = load
size0  in  2  port 0: 00 = byte, 01 = half, 10 = word, 11 = treated as word
sext0  in  1  port 0 load sign-extend (byte/half)
addr0  in  32  port 0 byte address
wdata0  in  32  port 0 store data, right-justified
ack0  out  1  port 0 completion, one-cycle pulse, registered
req1/we1/size1/sext1/addr1/wdata1  in  1/1/2/1/32/32  port 1, same meaning
ack1  out  1  port 1 completion pulse
rdata  out  32  load result, valid while ackN=1, registered
err  out  1  misalignment flag, valid while ackN=1
busy  out  1  1 when state != IDLE
mem_addr  out  32  to memory addr; always word-aligned ({addr[ADDR_WIDTH-1:2],2'b00})
mem_we  out  1  to memory MemWrite
mem_din  out  32  to memory din
mem_dout  in  32  from memory dout (combinational)

Behaviour:
- States: IDLE, ACCESS, MERGE, DONE.
- Reset: state IDLE; last_grant=1, so port 0 wins the first contention.
- Reset values: ack0=ack1=0, rdata=0, err=0, mem_we=0, mem_addr=0, mem_din=0.
- mem_we is forced 0 combinationally whenever reset=1. A reset mid-operation aborts the access: no write, no ack.
- Arbitration, in IDLE only: single request is granted. Both requesting: round-robin, grant goes to the port != last_grant. last_grant updates on grant.
- On grant, latch we/size/sext/addr/wdata and the port id into internal registers. Requester inputs are ignored until its ack.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
  - CHECK_ALIGN=1, misaligned: IDLE -> DONE, err=1, rdata=0, no memory write. Latency 2 cycles (grant edge, then ack).
- Load: IDLE -> ACCESS -> DONE.
  - ACCESS drives mem_addr and captures the formatted mem_dout into rdata.
  - ack in the 3rd cycle counting the grant cycle as 1.
- Load formatting, lane k=addr[1:0]:
  - Byte: mem_dout[8k+7:8k], zero- or sign-extended per sext.
  - Half: mem_dout[16j+15:16j] with j=addr[1], extended per sext.
  - Word: mem_dout as-is.
- Word store: IDLE -> ACCESS (mem_we=1, mem_din=wdata, write at end of ACCESS) -> DONE. rdata=0.
- Sub-word store: IDLE -> ACCESS -> MERGE -> DONE.
  - ACCESS: mem_we=0; capture mem_dout into the merge register.
  - MERGE: mem_we=1, mem_din = captured word with only the target lane(s) replaced by wdata[7:0] or wdata[15:0]. Other bytes unchanged.
  - ack one cycle later than a word store.
- DONE: pulse ack of the latched port only (never both); err valid. Return to IDLE next cycle.
  - The requester must drop req on the cycle after ack; req still high in IDLE is a new request.
  - Back-to-back throughput: one access per 3 cycles (4 for sub-word stores).
- mem_addr and mem_din hold their last value outside ACCESS/MERGE; mem_we=1 only in word-store ACCESS and in MERGE.
- Address wrap: only addr[ADDR_WIDTH-1:2] reaches the memory; higher bits are silently ignored. Address 0x400 aliases 0x000.
- Requests arriving while busy wait; no queueing beyond the held req line.

Test Plan:
- Reset then port 0 word store 0xDEADBEEF @0x010 -> mem_we=1 for exactly one cycle; ack0 on cycle 3; port 0 word load @0x010 -> rdata=0xDEADBEEF, err=0.
- Over word 0x11223344 @0x020: port 1 byte store 0xAA @0x022 -> memory 0x11AA3344, two mem_we-free cycles before the write; byte load sext=1 @0x022 -> 0xFFFFFFAA; sext=0 -> 0x000000AA.
- Half store 0xBEEF @0x026 then half load sext=1 -> 0xFFFFBEEF; bytes @0x024/0x025 unchanged.
- req0 and req1 asserted together and held through 4 transactions -> grants 0,1,0,1; ack0/ack1 never high together.
- Word load @0x013 with CHECK_ALIGN=1 -> ack on cycle 2, err=1, rdata=0, mem_we never asserted; half @0x011 likewise.
- Reset asserted during MERGE of a byte store -> no write (memory word unchanged), no ack, busy=0 next cycle, then port 0 wins first grant.
